// File: rtl/input_trigger_pkg.sv
// Shared types and helpers for the multi-channel trigger front-end.
// State encoding and the counter width function used by input_trigger_multi.
package input_trigger_pkg;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    SETTLE = 2'd1,
    BLOCK  = 2'd2
  } state_t;

  // Width large enough to hold the largest terminal count of any window.
  function automatic int cnt_width(input int deb, input int settle, input int rpt);
    int m;
    m = deb;
    if (settle > m) m = settle;
    if (rpt > m) m = rpt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/trigger_sync_edge.sv
// Two-flop synchroniser per trigger channel plus previous-value register,
// producing a one-cycle rising-edge vector on the synchronised inputs.
module trigger_sync_edge #(
  parameter int CHANNELS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] trigger,
  output logic [CHANNELS-1:0] sync_o,
  output logic [CHANNELS-1:0] trig_edge
);

  logic [CHANNELS-1:0] meta_q, meta_d;
  logic [CHANNELS-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] prev_q, prev_d;

  // prev follows sync in every state so a level held through a lock-out
  // never turns into a late edge.
  always_comb begin
    meta_d = trigger;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o    = sync_q;
  assign trig_edge = sync_q & ~prev_q;

endmodule

// File: rtl/input_trigger_multi.sv
// Trigger front-end: synchronised edges -> inc strobe + mask, settle -> ref strobe,
// then a lock-out window. Optional auto-repeat guarded by TRIGGER_AUTO_REPEAT_EN.
module input_trigger_multi
  import input_trigger_pkg::*;
#(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int SETTLE_CYCLES   = 10,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] trigger,
  output logic                inc_clk,
  output logic [CHANNELS-1:0] inc_mask,
  output logic                ref_clk,
  output logic                busy
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, SETTLE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLOCK_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] trig_edge;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                inc_clk_q, inc_clk_d;
  logic [CHANNELS-1:0] inc_mask_q, inc_mask_d;
  logic                ref_clk_q, ref_clk_d;

  logic                rpt_fire;
  logic [CHANNELS-1:0] rpt_mask;

  trigger_sync_edge #(
    .CHANNELS(CHANNELS)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .trigger  (trigger),
    .sync_o   (sync),
    .trig_edge(trig_edge)
  );

`ifdef TRIGGER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CHANNELS-1:0] last_mask_q, last_mask_d;
  logic [CNT_W-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic [CHANNELS-1:0] held;

  assign held     = sync & last_mask_q;
  assign rpt_mask = held;

  always_comb begin
    rpt_cnt_d   = '0;
    rpt_fire    = 1'b0;
    last_mask_d = inc_clk_q ? inc_mask_q : last_mask_q;
    // A fresh edge wins; the repeat counter only runs while idle and held.
    if (state_q == READY && trig_edge == '0 && held != '0) begin
      if (rpt_cnt_q == RPT_LAST) begin
        rpt_fire = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_mask_q <= '0;
      rpt_cnt_q   <= '0;
    end else begin
      last_mask_q <= last_mask_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  logic sync_unused;

  assign sync_unused = ^sync;
  assign rpt_fire    = 1'b0;
  assign rpt_mask    = '0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inc_clk_d  = 1'b0;
    inc_mask_d = '0;
    ref_clk_d  = 1'b0;
    case (state_q)
      READY: begin
        if (trig_edge != '0) begin
          inc_clk_d  = 1'b1;
          inc_mask_d = trig_edge;
          state_d    = SETTLE;
          cnt_d      = '0;
        end else if (rpt_fire) begin
          inc_clk_d  = 1'b1;
          inc_mask_d = rpt_mask;
          state_d    = SETTLE;
          cnt_d      = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          ref_clk_d = 1'b1;
          state_d   = BLOCK;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLOCK: begin
        if (cnt_q == BLOCK_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = BLOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset lands in BLOCK so inputs held high through reset cannot fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BLOCK;
      cnt_q      <= '0;
      inc_clk_q  <= 1'b0;
      inc_mask_q <= '0;
      ref_clk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inc_clk_q  <= inc_clk_d;
      inc_mask_q <= inc_mask_d;
      ref_clk_q  <= ref_clk_d;
    end
  end

  assign inc_clk  = inc_clk_q;
  assign inc_mask = inc_mask_q;
  assign ref_clk  = ref_clk_q;
  assign busy     = (state_q != READY);

endmodule

// File: tb/tb_input_trigger_multi.sv
// Directed bench for input_trigger_multi (CHANNELS=6, DEBOUNCE=20, SETTLE=10, REPEAT=50).
// Build with TRIGGER_AUTO_REPEAT_EN defined to exercise the repeat path.
module tb_input_trigger_multi;

  localparam int CH  = 6;
  localparam int DEB = 20;
  localparam int SET = 10;
  localparam int RPT = 50;

  logic          clk;
  logic          reset_n;
  logic [CH-1:0] trigger;
  logic          inc_clk;
  logic [CH-1:0] inc_mask;
  logic          ref_clk;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inc_count = 0;
  int ref_count = 0;
  int overlap = 0;
  int base_inc;
  int base_ref;

  input_trigger_multi #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES  (SET),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .trigger (trigger),
    .inc_clk (inc_clk),
    .inc_mask(inc_mask),
    .ref_clk (ref_clk),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inc_clk) inc_count++;
    if (ref_clk) ref_count++;
    if (inc_clk && ref_clk) overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (busy && i < 200) begin
      tick(1);
      i++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    // Power-on: all inputs high through reset, lock-out after release.
    trigger = 6'h3F;
    reset_n = 1'b0;
    tick(3);
    check_eq("rst_inc", 32'(inc_clk), 32'd0);
    check_eq("rst_ref", 32'(ref_clk), 32'd0);
    check_eq("rst_mask", 32'(inc_mask), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b1;
    tick(DEB - 1);
    check_eq("por_busy_hi", 32'(busy), 32'd1);
    tick(1);
    check_eq("por_busy_lo", 32'(busy), 32'd0);
    tick(20);
    check_eq("por_no_inc", 32'(inc_count), 32'd0);
    trigger = 6'h00;
    tick(5);
    check_eq("fall_no_inc", 32'(inc_count), 32'd0);

    // Single channel: inc at k+3, ref at k+13, busy falls at k+33.
    base_inc = inc_count;
    trigger = 6'h04;
    tick(2);
    check_eq("ch2_inc_early", 32'(inc_clk), 32'd0);
    tick(1);
    check_eq("ch2_inc", 32'(inc_clk), 32'd1);
    check_eq("ch2_mask", 32'(inc_mask), 32'h04);
    check_eq("ch2_busy", 32'(busy), 32'd1);
    tick(1);
    check_eq("ch2_inc_off", 32'(inc_clk), 32'd0);
    check_eq("ch2_mask_off", 32'(inc_mask), 32'd0);
    tick(8);
    check_eq("ch2_ref_early", 32'(ref_clk), 32'd0);
    tick(1);
    check_eq("ch2_ref", 32'(ref_clk), 32'd1);
    tick(1);
    check_eq("ch2_ref_off", 32'(ref_clk), 32'd0);
    trigger = 6'h00;
    tick(18);
    check_eq("ch2_busy_k32", 32'(busy), 32'd1);
    tick(1);
    check_eq("ch2_busy_k33", 32'(busy), 32'd0);
    check_eq("ch2_count", 32'(inc_count - base_inc), 32'd1);

    // Two channels in the same cycle: one strobe, both bits.
    base_inc = inc_count;
    trigger = 6'h21;
    tick(3);
    check_eq("dual_inc", 32'(inc_clk), 32'd1);
    check_eq("dual_mask", 32'(inc_mask), 32'h21);
    trigger = 6'h00;
    wait_ready("dual_ready");
    check_eq("dual_count", 32'(inc_count - base_inc), 32'd1);

    // Bouncing channel during the lock-out is dropped.
    base_inc = inc_count;
    trigger = 6'h02;
    tick(3);
    check_eq("bounce_inc", 32'(inc_clk), 32'd1);
    check_eq("bounce_mask", 32'(inc_mask), 32'h02);
    for (int i = 0; i < 8; i++) begin
      trigger[1] = ~trigger[1];
      tick(3);
    end
    trigger = 6'h00;
    wait_ready("bounce_ready");
    check_eq("bounce_dropped", 32'(inc_count - base_inc), 32'd1);
    trigger = 6'h02;
    tick(3);
    check_eq("bounce_next_inc", 32'(inc_clk), 32'd1);
    check_eq("bounce_next_mask", 32'(inc_mask), 32'h02);
    trigger = 6'h00;
    wait_ready("bounce_next_ready");

    // Reset during SETTLE aborts the pending ref and restarts the lock-out.
    trigger = 6'h10;
    tick(3);
    check_eq("mid_inc", 32'(inc_clk), 32'd1);
    check_eq("mid_mask", 32'(inc_mask), 32'h10);
    base_ref = ref_count;
    tick(4);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_inc", 32'(inc_clk), 32'd0);
    check_eq("mid_rst_mask", 32'(inc_mask), 32'd0);
    check_eq("mid_rst_ref", 32'(ref_clk), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd1);
    trigger = 6'h00;
    tick(2);
    reset_n = 1'b1;
    tick(DEB - 1);
    check_eq("mid_block_busy", 32'(busy), 32'd1);
    tick(1);
    check_eq("mid_block_done", 32'(busy), 32'd0);
    check_eq("mid_no_ref", 32'(ref_count - base_ref), 32'd0);

    // Held trigger: one strobe, or periodic repeats when enabled.
    base_inc = inc_count;
    trigger = 6'h08;
    tick(3);
    check_eq("hold_inc", 32'(inc_clk), 32'd1);
    check_eq("hold_mask", 32'(inc_mask), 32'h08);
`ifdef TRIGGER_AUTO_REPEAT_EN
    tick(SET + DEB + RPT - 1);
    check_eq("rpt_inc_early", 32'(inc_clk), 32'd0);
    tick(1);
    check_eq("rpt_inc", 32'(inc_clk), 32'd1);
    check_eq("rpt_mask", 32'(inc_mask), 32'h08);
    tick(1);
    check_eq("rpt_count", 32'(inc_count - base_inc), 32'd2);
`else
    tick(200);
    check_eq("hold_single", 32'(inc_count - base_inc), 32'd1);
`endif
    trigger = 6'h00;
    wait_ready("hold_ready");

    check_eq("no_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
